// File: rtl/data_memory_port.sv
// Single-port data memory responder: single-word writes, 1-16 word read bursts,
// out-of-range addresses reported per word on a pulsed response channel.
module data_memory_port #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MEM_AW     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_len,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_last,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_RSP   = 2'd1,
    RD_ISSUE = 2'd2,
    RD_DRAIN = 2'd3
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [3:0]            rd_cnt;

  // Read pipeline stage 1: array read data plus tags
  logic                  s1_valid, s1_err, s1_last;
  logic [DATA_WIDTH-1:0] s1_rdata;

  logic accept_c, req_in_range_c, rd_err_c, issue_c, issue_last_c, wr_en_c;

  // Next-state and per-cycle control
  always_comb begin
    state_next     = state;
    accept_c       = req_valid && req_ready;
    req_in_range_c = (req_addr >> MEM_AW) == '0;
    rd_err_c       = (rd_addr >> MEM_AW) != '0;
    issue_c        = 1'b0;
    issue_last_c   = rd_err_c || (rd_cnt == 4'd0);
    wr_en_c        = accept_c && req_write && req_in_range_c;
    case (state)
      IDLE: begin
        if (accept_c) state_next = req_write ? WR_RSP : RD_ISSUE;
      end
      WR_RSP: state_next = IDLE;
      RD_ISSUE: begin
        issue_c = 1'b1;
        if (issue_last_c) state_next = RD_DRAIN;
      end
      RD_DRAIN: begin
        // Output stage drains on the same edge that returns us to IDLE
        if (!s1_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, burst counters, pipeline tags and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_addr   <= '0;
      rd_cnt    <= '0;
      s1_valid  <= 1'b0;
      s1_err    <= 1'b0;
      s1_last   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      req_ready <= (state_next == IDLE);
      busy      <= (state_next != IDLE);

      if (accept_c && !req_write) begin
        rd_addr <= req_addr;
        rd_cnt  <= req_len;
      end else if (issue_c) begin
        rd_addr <= ADDR_WIDTH'(rd_addr + ADDR_WIDTH'(1));
        rd_cnt  <= 4'(rd_cnt - 4'd1);
      end

      s1_valid <= issue_c;
      s1_err   <= issue_c && rd_err_c;
      s1_last  <= issue_c && issue_last_c;

      if (accept_c && req_write) begin
        rsp_valid <= 1'b1;
        rsp_last  <= 1'b1;
        rsp_err   <= !req_in_range_c;
        rsp_rdata <= '0;
      end else begin
        rsp_valid <= s1_valid;
        rsp_last  <= s1_valid && s1_last;
        rsp_err   <= s1_valid && s1_err;
        rsp_rdata <= (s1_valid && !s1_err) ? s1_rdata : '0;
      end
    end
  end

  // Storage array: not reset, contents survive rst_n
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[req_addr[MEM_AW-1:0]] <= req_wdata;
    if (issue_c) s1_rdata <= mem[rd_addr[MEM_AW-1:0]];
  end

endmodule

// File: tb/tb_data_memory_port.sv
// Self-checking bench for data_memory_port: directed table, reset cases, and
// randomized traffic checked against an array-based reference model.
module tb_data_memory_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write;
  logic [15:0] req_addr, req_wdata;
  logic [3:0]  req_len;
  logic        req_ready, rsp_valid, rsp_last, rsp_err, busy;
  logic [15:0] rsp_rdata;

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] mdl [256];

  always #5 clk = ~clk;

  data_memory_port #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last), .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct {
    bit wr; int addr; int data; int len; bit poke;
    int exp_n; bit chk_d0; int exp_d0; bit exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ready"}, {31'd0, req_ready}, 0);
    chk({nm, "_busy"},  {31'd0, busy}, 0);
    chk({nm, "_valid"}, {31'd0, rsp_valid}, 0);
    chk({nm, "_last"},  {31'd0, rsp_last}, 0);
    chk({nm, "_err"},   {31'd0, rsp_err}, 0);
    chk({nm, "_rdata"}, {16'd0, rsp_rdata}, 0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !req_ready; i++) step();
    chk("ready_wait", {31'd0, req_ready}, 1);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, output bit err_o);
    bit exp_e;
    exp_e = (a >= 16'd256);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_len = 4'($urandom);
    step();
    req_valid = 1'b0;
    err_o = rsp_err;
    chk("wr_valid", {31'd0, rsp_valid}, 1);
    chk("wr_last",  {31'd0, rsp_last}, 1);
    chk("wr_err",   {31'd0, rsp_err}, {31'd0, exp_e});
    chk("wr_rdata", {16'd0, rsp_rdata}, 0);
    chk("wr_busy",  {31'd0, busy}, 1);
    chk("wr_ready", {31'd0, req_ready}, 0);
    if (!exp_e) mdl[a[7:0]] = d;
    step();
    chk("wr_end_valid", {31'd0, rsp_valid}, 0);
    chk("wr_end_ready", {31'd0, req_ready}, 1);
    chk("wr_end_busy",  {31'd0, busy}, 0);
  endtask

  task automatic do_read(input logic [15:0] a, input int len, input bit poke,
                         output int n_o, output int d0_o, output bit lerr_o);
    logic [15:0] ed [16];
    bit          ee [16], el [16];
    logic [15:0] aa;
    int n, k;
    n = 0;
    for (int i = 0; i <= len; i++) begin
      aa = 16'(a + 16'(i));
      n++;
      if (aa >= 16'd256) begin
        ed[i] = 16'd0; ee[i] = 1'b1; el[i] = 1'b1;
        break;
      end
      ed[i] = mdl[aa[7:0]]; ee[i] = 1'b0; el[i] = (i == len);
    end
    n_o = 0; d0_o = -1; lerr_o = 1'b0;
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = 4'(len);
    req_wdata = 16'($urandom);
    step();
    req_valid = 1'b0;
    chk("rd_busy0", {31'd0, busy}, 1);
    chk("rd_valid0", {31'd0, rsp_valid}, 0);
    for (int j = 1; j <= n + 2; j++) begin
      if (poke && j == 1) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'd12; req_wdata = 16'hBEEF;
      end
      step();
      req_valid = 1'b0;
      k = j - 2;
      chk("rd_valid", {31'd0, rsp_valid}, {31'd0, (j >= 2 && k < n)});
      if (rsp_valid) begin
        if (n_o == 0) d0_o = int'(rsp_rdata);
        n_o++;
        lerr_o = rsp_err;
      end
      if (j >= 2 && k < n) begin
        chk("rd_rdata", {16'd0, rsp_rdata}, {16'd0, ed[k]});
        chk("rd_err",   {31'd0, rsp_err}, {31'd0, ee[k]});
        chk("rd_last",  {31'd0, rsp_last}, {31'd0, el[k]});
      end
      if (j <= n + 1) chk("rd_busy", {31'd0, busy}, 1);
    end
    chk("rd_end_ready", {31'd0, req_ready}, 1);
    chk("rd_end_busy",  {31'd0, busy}, 0);
  endtask

  vec_t vt [12];

  initial begin
    int n, d0;
    bit le, we;
    logic [15:0] ra;

    vt[0]  = '{1, 127, 100, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{0, 127, 0,   0, 0, 1, 1, 100, 0};
    vt[2]  = '{1, 10,  15,  0, 0, 0, 0, 0, 0};
    vt[3]  = '{1, 11,  16,  0, 0, 0, 0, 0, 0};
    vt[4]  = '{1, 12,  17,  0, 0, 0, 0, 0, 0};
    vt[5]  = '{0, 10,  0,   2, 1, 3, 1, 15, 0};
    vt[6]  = '{1, 254, 5,   0, 0, 0, 0, 0, 0};
    vt[7]  = '{1, 255, 6,   0, 0, 0, 0, 0, 0};
    vt[8]  = '{0, 254, 0,   3, 0, 3, 1, 5, 1};
    vt[9]  = '{1, 256, 99,  0, 0, 0, 0, 0, 1};
    vt[10] = '{0, 0,   0,   0, 0, 1, 0, 0, 0};
    vt[11] = '{0, 12,  0,   0, 0, 1, 1, 17, 0};

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_len = '0;
    repeat (3) step();
    chk_all_zero("rst_init");
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("rst_rel_ready", {31'd0, req_ready}, 1);

    // Known contents everywhere so later reads are fully predictable
    for (int i = 0; i < 256; i++) do_write(16'(i), 16'($urandom), we);

    // Reset held with an active write request must not touch the array
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'd5; req_wdata = 16'h1234;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all_zero("rst_hold");
    end
    req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst_pre_edge_ready", {31'd0, req_ready}, 0);
    step();
    chk("rst_post_ready", {31'd0, req_ready}, 1);
    chk("rst_post_busy",  {31'd0, busy}, 0);
    do_read(16'd5, 0, 0, n, d0, le);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      if (vt[i].wr) begin
        do_write(16'(vt[i].addr), 16'(vt[i].data), we);
        chk("tbl_wr_err", {31'd0, we}, {31'd0, vt[i].exp_err});
      end else begin
        do_read(16'(vt[i].addr), vt[i].len, vt[i].poke, n, d0, le);
        chk("tbl_rd_n", n, vt[i].exp_n);
        chk("tbl_rd_lerr", {31'd0, le}, {31'd0, vt[i].exp_err});
        if (vt[i].chk_d0) chk("tbl_rd_d0", d0, vt[i].exp_d0);
      end
    end

    // Reset asserted while word 2 of an 8-word burst is on the bus
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'd10; req_len = 4'd7;
    step();
    req_valid = 1'b0;
    repeat (4) step();
    chk("mid_w2_valid", {31'd0, rsp_valid}, 1);
    chk("mid_w2_rdata", {16'd0, rsp_rdata}, 17);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_rst");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_rst_valid", {31'd0, rsp_valid}, 0);
    end
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("mid_rel_ready", {31'd0, req_ready}, 1);
    do_read(16'd10, 0, 0, n, d0, le);
    chk("mid_after_d0", d0, 15);

    // Randomized traffic against the reference model
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0:       ra = 16'($urandom_range(250, 270));
        1:       ra = 16'($urandom_range(16'hFFF0, 16'hFFFF));
        default: ra = 16'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 1) == 0) do_write(ra, 16'($urandom), we);
      else do_read(ra, int'($urandom_range(0, 15)), 0, n, d0, le);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/data_memory_port.md
# data_memory_port

Single-port data memory responder for one processing core. It sits on the far side of the core's address register and serves that register's 16-bit address output plus the control unit's read/write strobes through a valid/ready request channel and a pulsed response channel. Writes are single-word; reads are bursts of 1–16 words from consecutive addresses. Out-of-range accesses are flagged on the response channel rather than silently aliased.

## Interface
- ADDR_WIDTH, 16, width of request address (matches address register output)
- DATA_WIDTH, 16, memory word width
- MEM_AW, 8, log2 of memory depth; DEPTH = 2**MEM_AW words
- clk  in  1  system clock, rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  start address
- req_wdata  in  DATA_WIDTH  write data (ignored for reads)
- req_len  in  4  read burst length minus 1 (ignored for writes)
- req_ready  out  1  high only in IDLE; request accepted on edge where req_valid && req_ready
- rsp_valid  out  1  one-cycle pulse per response word
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errored words
- rsp_last  out  1  final response of the transaction
- rsp_err  out  1  address out of range for this word
- busy  out  1  high whenever state != IDLE

## Operation
- Memory: DEPTH x DATA_WIDTH array, not reset; contents survive rst_n.
- Range rule: address valid iff req_addr[ADDR_WIDTH-1:MEM_AW] == 0. Burst address increments by 1 in ADDR_WIDTH arithmetic; wrap of the full 16-bit address is impossible to reach usefully since any address >= DEPTH errors first.
- FSM states: IDLE, WR_RSP, RD_ISSUE, RD_DRAIN.
- IDLE: req_ready=1. Accepted write -> WR_RSP; accepted read -> RD_ISSUE, latch addr and remaining count = req_len.
- WR_RSP (exactly one cycle): rsp_valid=1, rsp_last=1, rsp_err per range rule; array written on accept edge only if in range. -> IDLE.
- RD_ISSUE: each cycle issue read at current addr, addr+1, count-1. Issuing an out-of-range address or the count=0 word ends issue -> RD_DRAIN. No words issued after an out-of-range one.
- RD_DRAIN: wait for pipeline empty, then -> IDLE.
- Read pipeline: registered array read, then registered output stage carrying valid/last/err tags.
- Errored read word: rsp_err=1, rsp_last=1, rsp_rdata=0; earlier words of the burst delivered normally.
- req_valid outside IDLE ignored (no queueing).
- Reset (async assert at any time, including mid-burst): state IDLE, pipeline valid bits cleared, all outputs 0 while rst_n=0; req_ready rises to 1 at the first rising edge after deassertion (synchronously released).

## Timing
- Let E0 = accept edge; En = n-th subsequent edge.
- Write: array updated at E0; rsp_valid high E0..E1; busy high E0..E1; req_ready high again after E1 (2-cycle write throughput).
- Read burst of N = req_len+1 words: word k (k = 0..N-1) presented with rsp_valid=1 during E(k+2)..E(k+3); rsp_last on word N-1 (or errored word). Back-to-back, no gaps.
- Read completion: IDLE and req_ready=1 after E(N+2); total occupancy N+2 cycles.
- Read-after-write: new value visible to a read accepted at or after E1 of the write.
- All outputs registered; no combinational path from req_* to rsp_*. req_ready depends only on state.

## Test plan
- Reset: hold rst_n=0 5 cycles with req_valid=1 -> all outputs 0, no array write; after release req_ready=1, busy=0.
- Write 100 to addr 127, then read addr 127 len 0 -> write rsp_valid 1 cycle after accept, err=0; read rsp_rdata=100, rsp_last=1 at E2, req_ready back after E3.
- Write 15@10, 16@11, 17@12; read addr 10 len 2 -> rsp_rdata 15,16,17 on three consecutive cycles, rsp_last only on 17, req_valid pulsed mid-burst ignored.
- Write 5@254, 6@255; read addr 254 len 3 -> 5, 6, then third pulse rsp_err=1 rsp_last=1 rdata=0; no fourth pulse; IDLE after.
- Write 99 to addr 256 -> rsp_err=1, rsp_last=1; subsequent read of addr 0 returns its previous value (no aliasing).
- Assert rst_n low during word 2 of a len=7 burst -> rsp_valid drops immediately, no further pulses; after release, read addr 10 len 0 returns 15.
